fifo_drain_reader: RTL and testbench

//  Consumer-side engine for the 16-deep byte FIFO: watches fifo_empty/count, issues pop,

---
 rtl/fifo_drain_reader.sv | 148 ++++++++++++++
 tb/tb_fifo_drain_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_reader.sv
// fifo_drain_reader: consumer-side engine for a 16-deep byte FIFO.
// It pops the FIFO in threshold-triggered bursts, or to empty on a flush request.
// Each popped byte is captured one cycle later into a small skid buffer.
// The buffer is presented downstream on a valid/ready stream.
module fifo_drain_reader #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 5,
    parameter int THRESHOLD = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              pop,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [15:0]       pop_cnt
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_inflight;
    logic [OCC_W-1:0]    r_occ;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [DATA_W-1:0]   r_mem [BUF_DEPTH];
    logic [15:0]         r_pop_cnt;

    logic                w_pop;
    logic                w_deq;
    logic                w_credit_ok;
    logic                w_thresh_hit;
    logic                w_flush_clear;

    // Circular pointer advance; handles depths that are not a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (32'(p) == BUF_DEPTH - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Credit counts bytes already buffered plus the one still on its way from the FIFO,
    // so a capture can never land in a full buffer.
    assign w_credit_ok   = (32'(r_occ) + 32'(r_inflight)) < 32'(BUF_DEPTH);
    assign w_thresh_hit  = 32'(fifo_count) >= 32'(THRESHOLD);
    assign w_flush_clear = fifo_empty && !r_inflight && (r_occ == '0);
    assign w_deq         = m_valid && m_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: threshold starts a burst, flush overrides and runs to empty.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (flush_req) begin
                    w_next_state = S_FLUSH;
                end else if (w_thresh_hit) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (flush_req) begin
                    w_next_state = S_FLUSH;
                end else if (fifo_empty && !w_pop) begin
                    w_next_state = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (w_flush_clear) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: pop gated by state, FIFO flag and buffer credit; flush completion pulse.
    always_comb begin
        w_pop      = (r_state != S_IDLE) && !fifo_empty && w_credit_ok;
        flush_done = (r_state == S_FLUSH) && w_flush_clear;
        busy       = (r_state != S_IDLE) || (r_occ != '0) || r_inflight;
    end

    assign pop = w_pop;

    // Read-in-flight flag, buffer pointers/occupancy and pop counter.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_inflight <= 1'b0;
            r_occ      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pop_cnt  <= '0;
        end else begin
            r_inflight <= w_pop;
            if (r_inflight) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({r_inflight, w_deq})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_pop) begin
                r_pop_cnt <= r_pop_cnt + 16'd1;
            end
        end
    end

    // Buffer storage: the FIFO read data is valid the cycle after pop, so capture on inflight.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_mem[r_wr_ptr] <= fifo_data_out;
        end
    end

    assign m_valid = (r_occ != '0);
    assign m_data  = m_valid ? r_mem[r_rd_ptr] : '0;
    assign pop_cnt = r_pop_cnt;

endmodule

// File: tb/tb_fifo_drain_reader.sv
// tb_fifo_drain_reader: directed bench with a behavioural FIFO and a byte scoreboard.
module tb_fifo_drain_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        fifo_empty;
    logic [4:0]  fifo_count = '0;
    logic [7:0]  fifo_data_out = '0;
    logic        pop;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        busy;
    logic [15:0] pop_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    int          flush_pulses = 0;

    logic [7:0]  fq[$];
    logic [7:0]  exp_q[$];
    logic        push_req = 1'b0;
    logic [7:0]  push_data = '0;

    logic        hold_prev = 1'b0;
    logic [7:0]  hold_data = '0;
    logic        rst_prev = 1'b1;

    fifo_drain_reader #(
        .DATA_W(8), .CNT_W(5), .THRESHOLD(4), .BUF_DEPTH(2)
    ) dut (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .fifo_data_out(fifo_data_out), .pop(pop), .flush_req(flush_req),
        .flush_done(flush_done), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .busy(busy), .pop_cnt(pop_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered flags, read data valid the cycle after pop.
    always @(posedge clk) begin
        if (pop && fq.size() != 0) fifo_data_out <= fq.pop_front();
        if (push_req) fq.push_back(push_data);
        fifo_count <= 5'(fq.size());
    end
    assign fifo_empty = (fifo_count == 5'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] d);
        push_req  = 1'b1;
        push_data = d;
        exp_q.push_back(d);
        step();
        push_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        step();
        while (busy && n < 200) begin
            step();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    // Stream monitor: scoreboard pops, hold-under-backpressure, flush and pop-safety checks.
    always @(negedge clk) begin
        if (pop) check("pop_while_empty", fifo_empty, 0);
        if (flush_done) begin
            flush_pulses++;
            check("flush_done_fifo_empty", fifo_count, 0);
            check("flush_done_buf_empty", m_valid, 0);
        end
        if (hold_prev && !rstn && !rst_prev) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, hold_data);
        end
        if (m_valid && m_ready && !rstn) begin
            if (exp_q.size() == 0) check("unexpected_byte", m_data, 32'h100);
            else check("stream_data", m_data, exp_q.pop_front());
        end
        hold_prev = m_valid && !m_ready;
        hold_data = m_data;
        rst_prev  = rstn;
    end

    initial begin
        // Reset held for two cycles
        rstn = 1'b1;
        step();
        step();
        check("rst_pop", pop, 0);
        check("rst_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pop_cnt", pop_cnt, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_m_data", m_data, 0);
        rstn = 1'b0;
        step();

        // Threshold drain
        m_ready = 1'b1;
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        step();
        step();
        check("thr_below_pop", pop, 0);
        check("thr_below_busy", busy, 0);
        push(8'hA3);
        check("thr_pop_not_yet", pop, 0);
        step();
        check("thr_pop_starts", pop, 1);
        wait_idle("thr");
        check("thr_pop_cnt", pop_cnt, 4);
        check("thr_all_out", exp_q.size(), 0);

        // Backpressure during a 6-byte drain
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'hB0 + i));
        repeat (8) step();
        check("bp_pop_cnt", pop_cnt, 6);
        check("bp_fifo_left", fifo_count, 4);
        check("bp_valid", m_valid, 1);
        check("bp_head", m_data, 8'hB0);
        m_ready = 1'b1;
        wait_idle("bp");
        check("bp_pop_cnt_end", pop_cnt, 10);
        check("bp_all_out", exp_q.size(), 0);

        // Flush below threshold
        push(8'hD0);
        push(8'hD1);
        step();
        step();
        check("fl_below_pop", pop, 0);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        wait_idle("fl");
        check("fl_pulses", flush_pulses, 1);
        check("fl_pop_cnt", pop_cnt, 12);
        check("fl_all_out", exp_q.size(), 0);

        // Single entry flush
        push(8'hE0);
        step();
        check("se_count", fifo_count, 1);
        check("se_pop_idle", pop, 0);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        wait_idle("se");
        check("se_pop_cnt", pop_cnt, 13);
        check("se_pulses", flush_pulses, 2);
        check("se_all_out", exp_q.size(), 0);

        // Reset in the middle of a stalled drain with the buffer full
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
        repeat (8) step();
        check("mr_valid_before", m_valid, 1);
        check("mr_pop_cnt_before", pop_cnt, 15);
        rstn = 1'b1;
        step();
        check("mr_valid", m_valid, 0);
        check("mr_m_data", m_data, 0);
        check("mr_busy", busy, 0);
        check("mr_pop_cnt", pop_cnt, 0);
        check("mr_pop", pop, 0);
        exp_q = fq;
        rstn = 1'b0;
        m_ready = 1'b1;
        wait_idle("mr");
        check("mr_pop_cnt_after", pop_cnt, 4);
        check("mr_all_out", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
